decoder_strobe: RTL and testbench
=================================

DECODER_STROBE -- requirements
Module: decoder_strobe

Interface
REQ-001 Parameter HOLD_CYCLES, default 4: number of clock cycles each decoded one-hot word is driven; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 decoder_in  input  2  binary code to decode; 0..3.
REQ-005 in_valid  input  1  decoder_in is valid this cycle.
REQ-006 in_ready  output  1  block accepts a code this cycle.
REQ-007 decoder_out  output  4  registered one-hot word; bit N high for code N.
REQ-008 out_valid  output  1  decoder_out carries a valid one-hot word.
REQ-009 busy  output  1  high whenever the state is not IDLE.
REQ-010 overrun_clr  input  1  synchronous clear of overrun.
REQ-011 overrun  output  1  sticky flag: code offered while not ready.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, DRIVE, GAP.
REQ-013 in_ready SHALL be 1 only in IDLE; a code is accepted on a rising edge where state=IDLE and in_valid=1.
REQ-014 On acceptance, the block SHALL latch decoder_in, load the hold counter with HOLD_CYCLES-1, and enter DRIVE on the same edge.
REQ-015 In DRIVE, decoder_out SHALL equal 1<<code (0->0001, 1->0010, 2->0100, 3->1000), and out_valid SHALL be 1.
REQ-016 Latency: decoder_out SHALL become valid in the first cycle after the accepting edge (one-cycle latency) and SHALL stay stable for exactly HOLD_CYCLES cycles.
REQ-017 In DRIVE, the counter SHALL decrement every cycle; when it reaches 0, the FSM SHALL go to GAP on the next edge.
REQ-018 GAP SHALL last exactly one cycle with decoder_out=0000, out_valid=0, and in_ready=0, then return to IDLE.
REQ-019 In IDLE, decoder_out SHALL be 0000 and out_valid SHALL be 0.
REQ-020 Maximum throughput SHALL be one code per HOLD_CYCLES+2 cycles.
REQ-021 decoder_out SHALL never have more than one bit set in any cycle.
REQ-022 Changes on decoder_in after acceptance SHALL NOT affect decoder_out.
REQ-023 With HOLD_CYCLES=1, DRIVE SHALL last exactly one cycle.

Reset
REQ-024 When reset asserts, at any time including mid-DRIVE or GAP, the block SHALL immediately force state=IDLE, counter=0, latched code=0, decoder_out=0000, out_valid=0, busy=0, and overrun=0.
REQ-025 in_ready SHALL be 0 while reset is high and SHALL become 1 in the first cycle after reset deasserts.
REQ-026 No code SHALL be accepted on an edge where reset is high.

Configuration
REQ-027 Macro DECODER_STROBE_OVERRUN_EN SHALL gate the overrun detector.
REQ-028 With the macro defined, overrun SHALL set on any edge where in_valid=1 and in_ready=0 (DRIVE or GAP), and SHALL clear on an edge with overrun_clr=1.
REQ-029 If set and clear conditions occur on the same edge, set SHALL win.
REQ-030 With the macro undefined, overrun SHALL be tied to 0, overrun_clr SHALL be ignored, and the port list SHALL be unchanged.

Verification
REQ-031 Reset release, HOLD_CYCLES=4: in_valid=1 with decoder_in=2 for one cycle -> decoder_out=0100 with out_valid=1 for exactly cycles 1-4 after accept, then 0000 in GAP, and in_ready=1 again at cycle 6.
REQ-032 Sweep codes 0..3 back-to-back with in_valid held high -> outputs 0001, 0010, 0100, 1000, each accepted exactly HOLD_CYCLES+2 cycles apart; no two bits ever high together.
REQ-033 Assert reset during the 2nd DRIVE cycle of code 3 -> decoder_out=0000, busy=0, and out_valid=0 without waiting for a clock edge; in_ready=1 in the first cycle after release.
REQ-034 With macro defined: offer code 1 during DRIVE -> overrun=1 and the code is ignored (decoder_out unchanged); pulse overrun_clr -> overrun=0; assert set and clear on the same edge -> overrun=1.
REQ-035 With macro undefined: repeat REQ-034 stimulus -> overrun stays 0 throughout.
REQ-036 HOLD_CYCLES=1: code 0 accepted -> 0001 for exactly one cycle, GAP for one cycle, next accept three cycles after the first.

Source files
------------

// File: rtl/decoder_strobe_if.sv
// Handshake and output bundle for decoder_strobe.
// The bench drives through the master modport; the decoder is the slave.
interface decoder_strobe_if;
    logic [1:0] decoder_in;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] decoder_out;
    logic       out_valid;
    logic       busy;
    logic       overrun_clr;
    logic       overrun;
    logic [1:0] dbg_state;

    modport master (
        output decoder_in, in_valid, overrun_clr,
        input  in_ready, decoder_out, out_valid, busy, overrun, dbg_state
    );

    modport slave (
        input  decoder_in, in_valid, overrun_clr,
        output in_ready, decoder_out, out_valid, busy, overrun, dbg_state
    );
endinterface

// File: rtl/decoder_strobe.sv
// 2-to-4 one-hot decoder that holds each word for HOLD_CYCLES cycles, then idles one cycle.
// Optional sticky overrun detector enabled by DECODER_STROBE_OVERRUN_EN.
module decoder_strobe #(
    parameter int HOLD_CYCLES = 4
) (
    input logic            clk,
    input logic            reset,
    decoder_strobe_if.slave bus
);
    // Handshake: a code transfers on a rising edge where in_valid=1 and in_ready=1;
    // in_ready is high only in IDLE and never while reset is asserted.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [7:0] LOAD = 8'(HOLD_CYCLES - 1);

    state_t     r_state, w_next;
    logic [7:0] r_cnt, w_cnt_next;
    logic [3:0] r_out, w_out_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
            r_out   <= 4'b0000;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_out   <= w_out_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_out_next = r_out;
        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_next     = DRIVE;
                    w_cnt_next = LOAD;
                    w_out_next = 4'b0001 << bus.decoder_in;
                end
            end
            DRIVE: begin
                // The counter reaching zero marks the last of the HOLD_CYCLES drive cycles.
                if (r_cnt == 8'd0) begin
                    w_next     = GAP;
                    w_out_next = 4'b0000;
                end else begin
                    w_cnt_next = r_cnt - 8'd1;
                end
            end
            GAP: begin
                w_next = IDLE;
            end
            default: begin
                w_next     = IDLE;
                w_cnt_next = 8'd0;
                w_out_next = 4'b0000;
            end
        endcase
    end

    assign bus.in_ready    = (r_state == IDLE) && !reset;
    assign bus.busy        = (r_state != IDLE);
    assign bus.out_valid   = (r_state == DRIVE);
    assign bus.decoder_out = r_out;
    assign bus.dbg_state   = r_state;

`ifdef DECODER_STROBE_OVERRUN_EN
    logic r_overrun;

    // Set has priority over clear when both land on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overrun <= 1'b0;
        end else if (bus.in_valid && (r_state != IDLE)) begin
            r_overrun <= 1'b1;
        end else if (bus.overrun_clr) begin
            r_overrun <= 1'b0;
        end
    end

    assign bus.overrun = r_overrun;
`else
    assign bus.overrun = 1'b0;
`endif

endmodule

// File: tb/tb_decoder_strobe.sv
// Bench for decoder_strobe: HOLD_CYCLES=4 and HOLD_CYCLES=1 instances checked against
// a timestamp-based model every cycle, plus directed literal checks.
module tb_decoder_strobe;
  localparam int N = 2;
`ifdef DECODER_STROBE_OVERRUN_EN
  localparam bit OV_EN = 1'b1;
`else
  localparam bit OV_EN = 1'b0;
`endif

  logic clk;
  logic reset;

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  decoder_strobe_if if0 ();
  decoder_strobe_if if1 ();

  decoder_strobe #(.HOLD_CYCLES(4)) dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
  decoder_strobe #(.HOLD_CYCLES(1)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));

  logic [1:0] din [N];
  logic       vld [N];
  logic       clr [N];
  logic [3:0] dout [N];
  logic       ovld [N];
  logic       rdy [N];
  logic       bsy [N];
  logic       ovr [N];

  assign if0.decoder_in  = din[0];
  assign if0.in_valid    = vld[0];
  assign if0.overrun_clr = clr[0];
  assign if1.decoder_in  = din[1];
  assign if1.in_valid    = vld[1];
  assign if1.overrun_clr = clr[1];

  assign dout[0] = if0.decoder_out;
  assign ovld[0] = if0.out_valid;
  assign rdy[0]  = if0.in_ready;
  assign bsy[0]  = if0.busy;
  assign ovr[0]  = if0.overrun;
  assign dout[1] = if1.decoder_out;
  assign ovld[1] = if1.out_valid;
  assign rdy[1]  = if1.in_ready;
  assign bsy[1]  = if1.busy;
  assign ovr[1]  = if1.overrun;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a word is accepted on edge acc; the cycle after edge k
  // has phase k-acc. Phases 1..H drive, H+1 is the gap, anything later is idle.
  int hold [N] = '{4, 1};
  int acc  [N] = '{-1, -1};
  logic [1:0] code_m [N];
  bit ov_m [N] = '{1'b0, 1'b0};
  int k = 0;

  function automatic int phase(input int i);
    return (acc[i] < 0) ? 100000 : (k - acc[i]);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (reset) begin
        acc[i]  = -1;
        ov_m[i] = 1'b0;
      end else begin
        int  ph;
        bit  ready;
        ph    = phase(i);
        ready = (ph >= hold[i] + 2);
        if (OV_EN && vld[i] && !ready) ov_m[i] = 1'b1;
        else if (clr[i]) ov_m[i] = 1'b0;
        if (vld[i] && ready) begin
          acc[i]    = k;
          code_m[i] = din[i];
        end
      end
    end
    k++;
  end

  // scoreboard: expected output tuple per instance, compared on every falling edge
  logic [7:0] exp_q [$];

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      logic [3:0] e_out;
      logic       e_vld, e_rdy, e_bsy, e_ovr;
      int ph;
      ph    = phase(i);
      e_out = 4'b0000;
      e_vld = 1'b0;
      e_rdy = 1'b0;
      e_bsy = 1'b0;
      e_ovr = 1'b0;
      if (!reset) begin
        e_ovr = ov_m[i];
        if (ph >= 1 && ph <= hold[i]) begin
          e_out = 4'(1 << code_m[i]);
          e_vld = 1'b1;
          e_bsy = 1'b1;
        end else if (ph == hold[i] + 1) begin
          e_bsy = 1'b1;
        end else begin
          e_rdy = 1'b1;
        end
      end
      exp_q.push_back({e_out, e_vld, e_rdy, e_bsy, e_ovr});
      begin
        logic [7:0] e;
        e = exp_q.pop_front();
        chk($sformatf("model_out%0d", i), 32'(dout[i]), 32'(e[7:4]));
        chk($sformatf("model_vld%0d", i), 32'(ovld[i]), 32'(e[3]));
        chk($sformatf("model_rdy%0d", i), 32'(rdy[i]), 32'(e[2]));
        chk($sformatf("model_bsy%0d", i), 32'(bsy[i]), 32'(e[1]));
        chk($sformatf("model_ovr%0d", i), 32'(ovr[i]), 32'(e[0]));
      end
      chk($sformatf("onehot%0d", i), 32'($countones(dout[i]) <= 1), 32'd1);
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int i = 0; i < N; i++) begin
      vld[i] = 1'b0;
      clr[i] = 1'b0;
      din[i] = 2'd0;
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_all();

    // reset state
    @(negedge clk);
    chk("rst_ready", 32'(rdy[0]), 32'd0);
    chk("rst_out", 32'(dout[0]), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("release_ready0", 32'(rdy[0]), 32'd1);
    chk("release_ready1", 32'(rdy[1]), 32'd1);
    tick();

    // single code 2 on HOLD_CYCLES=4, decoder_in changed after acceptance
    vld[0] = 1'b1;
    din[0] = 2'd2;
    tick();
    vld[0] = 1'b0;
    din[0] = 2'd3;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c <= 4) begin
        chk($sformatf("single_out_c%0d", c), 32'(dout[0]), 32'h4);
        chk($sformatf("single_vld_c%0d", c), 32'(ovld[0]), 32'd1);
      end else if (c == 5) begin
        chk("single_gap_out", 32'(dout[0]), 32'h0);
        chk("single_gap_rdy", 32'(rdy[0]), 32'd0);
      end else begin
        chk("single_rdy_c6", 32'(rdy[0]), 32'd1);
      end
    end
    tick();

    // HOLD_CYCLES=1: code 0, in_valid held high, re-accept three cycles later
    vld[1] = 1'b1;
    din[1] = 2'd0;
    tick();
    @(negedge clk);
    chk("h1_out_c1", 32'(dout[1]), 32'h1);
    @(negedge clk);
    chk("h1_gap_out", 32'(dout[1]), 32'h0);
    chk("h1_gap_rdy", 32'(rdy[1]), 32'd0);
    @(negedge clk);
    chk("h1_rdy_c3", 32'(rdy[1]), 32'd1);
    @(negedge clk);
    chk("h1_out_c4", 32'(dout[1]), 32'h1);
    vld[1] = 1'b0;
    tick();

    // back-to-back sweep of codes 0..3 with in_valid held high
    din[0] = 2'd0;
    vld[0] = 1'b1;
    @(posedge clk);
    for (int j = 0; j < 4; j++) begin
      logic [3:0] onehot;
      onehot = 4'b0001 << j;
      for (int c = 1; c <= 6; c++) begin
        @(negedge clk);
        if (c <= 4) begin
          chk($sformatf("sweep_out_j%0d_c%0d", j, c), 32'(dout[0]), 32'(onehot));
        end else if (c == 5) begin
          chk($sformatf("sweep_gap_j%0d", j), 32'(dout[0]), 32'h0);
          din[0] = 2'(j + 1);
        end else begin
          chk($sformatf("sweep_rdy_j%0d", j), 32'(rdy[0]), 32'd1);
          if (j == 3) vld[0] = 1'b0;
        end
      end
    end
    tick();

    // overrun: clear, offer during DRIVE, clear, then set+clear on one edge
    clr[0] = 1'b1;
    clr[1] = 1'b1;
    tick();
    clr[0] = 1'b0;
    clr[1] = 1'b0;
    @(negedge clk);
    chk("ovr_cleared", 32'(ovr[0]), 32'd0);
    tick();
    vld[0] = 1'b1;
    din[0] = 2'd3;
    tick();
    vld[0] = 1'b0;
    tick();
    vld[0] = 1'b1;
    din[0] = 2'd1;
    tick();
    vld[0] = 1'b0;
    @(negedge clk);
    chk("ovr_ignored_out", 32'(dout[0]), 32'h8);
    chk("ovr_set", 32'(ovr[0]), 32'(OV_EN));
    tick();
    clr[0] = 1'b1;
    tick();
    clr[0] = 1'b0;
    @(negedge clk);
    chk("ovr_clr", 32'(ovr[0]), 32'd0);
    repeat (3) tick();
    vld[0] = 1'b1;
    din[0] = 2'd2;
    tick();
    vld[0] = 1'b1;
    din[0] = 2'd0;
    clr[0] = 1'b1;
    tick();
    vld[0] = 1'b0;
    clr[0] = 1'b0;
    @(negedge clk);
    chk("ovr_set_wins", 32'(ovr[0]), 32'(OV_EN));
    chk("ovr_set_wins_out", 32'(dout[0]), 32'h4);
    repeat (6) tick();

    // asynchronous reset in the second DRIVE cycle of code 3
    vld[0] = 1'b1;
    din[0] = 2'd3;
    tick();
    vld[0] = 1'b0;
    tick();
    #2 reset = 1'b1;
    #1;
    chk("async_out", 32'(dout[0]), 32'h0);
    chk("async_busy", 32'(bsy[0]), 32'd0);
    chk("async_vld", 32'(ovld[0]), 32'd0);
    chk("async_rdy", 32'(rdy[0]), 32'd0);
    chk("async_ovr", 32'(ovr[0]), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("async_release_rdy", 32'(rdy[0]), 32'd1);
    tick();

    // randomized traffic, including occasional resets
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < N; i++) begin
        vld[i] = 1'($urandom_range(0, 1));
        din[i] = 2'($urandom_range(0, 3));
        clr[i] = ($urandom_range(0, 7) == 0);
      end
      reset = ($urandom_range(0, 99) == 0);
      tick();
    end
    reset = 1'b0;
    idle_all();
    repeat (8) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
